// File: rtl/cpu_trap_ctl_if.sv
// Redirect handshake between the trap sequencer (master) and fetch (slave).
interface cpu_trap_ctl_if;
    logic        redirect_valid_o;
    logic [31:0] redirect_addr_o;
    logic        redirect_ready_i;

    modport master (
        output redirect_valid_o,
        output redirect_addr_o,
        input  redirect_ready_i
    );

    modport slave (
        input  redirect_valid_o,
        input  redirect_addr_o,
        output redirect_ready_i
    );
endinterface

// File: rtl/cpu_trap_ctl.sv
// Trap sequencer: arbitrates exceptions, mret and machine interrupts, drains
// the pipeline, pulses mtrap/mret to the CSR block and redirects fetch.
module cpu_trap_ctl #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          exc_valid_i,
    input  logic [30:0]   exc_cause_i,
    input  logic [31:0]   exc_pc_i,
    input  logic          mret_req_i,
    input  logic [31:0]   next_pc_i,
    input  logic          irq_ext_i,
    input  logic          irq_timer_i,
    input  logic          irq_soft_i,
    input  logic          mstatus_mie_i,
    input  logic [2:0]    mie_i,
    input  logic          drained_i,
    input  logic [31:0]   trap_addr_i,
    cpu_trap_ctl_if.master redir,
    output logic          flush_o,
    output logic          stall_o,
    output logic          mtrap_o,
    output logic          mret_o,
    output logic [31:0]   mcause_o,
    output logic [31:0]   pc_o,
    output logic [2:0]    mip_o,
    output logic          drain_err_o
);

    localparam int unsigned      CNT_W    = (DRAIN_TIMEOUT > 32) ? $clog2(DRAIN_TIMEOUT) : 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_is_ret;
    logic [31:0]            r_cause;
    logic [31:0]            r_pc;
    logic [SYNC_STAGES-1:0] r_meip_sync;
    logic                   r_mtip;
    logic                   r_msip;
    logic                   r_flush;
    logic                   r_stall;
    logic                   r_mtrap;
    logic                   r_mret;
    logic [31:0]            r_mcause;
    logic [31:0]            r_pc_out;
    logic                   r_redirect_valid;
    logic [31:0]            r_redirect_addr;
    logic                   r_drain_err;

    logic [2:0]             w_mip;
    logic [2:0]             w_pend;
    logic                   w_irq_take;
    logic [3:0]             w_irq_code;

    // Pending bits and interrupt selection: MEI > MSI > MTI.
    assign w_mip      = {r_meip_sync[SYNC_STAGES-1], r_mtip, r_msip};
    assign w_pend     = w_mip & mie_i;
    assign w_irq_take = mstatus_mie_i & (|w_pend);
    assign w_irq_code = w_pend[2] ? 4'd11 : (w_pend[0] ? 4'd3 : 4'd7);

    // Synchronise the external interrupt and register the synchronous ones.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_meip_sync <= '0;
            r_mtip      <= 1'b0;
            r_msip      <= 1'b0;
        end else begin
            r_meip_sync <= {r_meip_sync[SYNC_STAGES-2:0], irq_ext_i};
            r_mtip      <= irq_timer_i;
            r_msip      <= irq_soft_i;
        end
    end

    // Trap sequencing FSM with registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_is_ret         <= 1'b0;
            r_cause          <= '0;
            r_pc             <= '0;
            r_flush          <= 1'b0;
            r_stall          <= 1'b0;
            r_mtrap          <= 1'b0;
            r_mret           <= 1'b0;
            r_mcause         <= '0;
            r_pc_out         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_addr  <= '0;
            r_drain_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_flush <= 1'b0;
                    r_stall <= 1'b0;
                    r_cnt   <= '0;
                    if (exc_valid_i) begin
                        r_is_ret <= 1'b0;
                        r_cause  <= {1'b0, exc_cause_i};
                        r_pc     <= exc_pc_i;
                        r_flush  <= 1'b1;
                        r_stall  <= 1'b1;
                        r_state  <= ST_DRAIN;
                    end else if (mret_req_i) begin
                        r_is_ret <= 1'b1;
                        r_cause  <= '0;
                        r_pc     <= '0;
                        r_flush  <= 1'b1;
                        r_stall  <= 1'b1;
                        r_state  <= ST_DRAIN;
                    end else if (w_irq_take) begin
                        r_is_ret <= 1'b0;
                        r_cause  <= {1'b1, 27'd0, w_irq_code};
                        r_pc     <= next_pc_i;
                        r_flush  <= 1'b1;
                        r_stall  <= 1'b1;
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (drained_i || (r_cnt == CNT_LAST)) begin
                        if (!drained_i) begin
                            r_drain_err <= 1'b1;
                        end
                        r_flush <= 1'b0;
                        r_stall <= 1'b1;
                        if (r_is_ret) begin
                            r_mret <= 1'b1;
                        end else begin
                            r_mtrap  <= 1'b1;
                            r_mcause <= r_cause;
                            r_pc_out <= r_pc;
                        end
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_mtrap          <= 1'b0;
                    r_mret           <= 1'b0;
                    r_mcause         <= '0;
                    r_pc_out         <= '0;
                    r_redirect_addr  <= trap_addr_i;
                    r_redirect_valid <= 1'b1;
                    r_state          <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (redir.redirect_ready_i) begin
                        r_redirect_valid <= 1'b0;
                        r_stall          <= 1'b0;
                        r_state          <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign flush_o                = r_flush;
    assign stall_o                = r_stall;
    assign mtrap_o                = r_mtrap;
    assign mret_o                 = r_mret;
    assign mcause_o               = r_mcause;
    assign pc_o                   = r_pc_out;
    assign mip_o                  = w_mip;
    assign drain_err_o            = r_drain_err;
    assign redir.redirect_valid_o = r_redirect_valid;
    assign redir.redirect_addr_o  = r_redirect_addr;

endmodule
